mem_rr_ctrl: RTL and testbench

Two-requester round-robin controller for the JK-flip-flop memory array (WORDS words × WIDTH bits, one-hot word select, shared rw strobe and clear). It accepts read/write requests over req/ack handshakes, arbitrates fairly, and sequences the memory's address-select, rw strobe and clear lines so each access follows a fixed, glitch-safe setup/strobe/capture cycle. It sits between the register-level users and the memory bank.

---
 rtl/mem_rr_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mem_rr_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rr_ctrl
//  Purpose  : Two-requester round-robin controller for a JK-flip-flop memory
//             array. Accepts read/write requests over req/ack handshakes,
//             arbitrates fairly, and drives the memory's one-hot select,
//             rw strobe and clear line through a fixed
//             setup / strobe / capture sequence.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             req0/1, rw0/1         - requests and direction (1 = write)
//             addr0/1, wdata0/1     - word address and write data
//             clr_req / clr_done    - whole-array clear request / done pulse
//             ack0/1, rdata         - completion pulses and read data
//             busy                  - high in every state except IDLE
//             mem_add, mem_rw,
//             mem_din, mem_clear    - memory-side controls (all registered)
//             mem_dout              - OR of all memory word outputs
//  Revision : 1.0 - initial release
// ============================================================================
module mem_rr_ctrl #(
    parameter int WORDS = 4,
    parameter int WIDTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             rw0,
    input  logic             rw1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             clr_req,
    output logic             ack0,
    output logic             ack1,
    output logic             clr_done,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic [WORDS-1:0] mem_add,
    output logic             mem_rw,
    output logic [WIDTH-1:0] mem_din,
    output logic             mem_clear,
    input  logic [WIDTH-1:0] mem_dout
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SETUP  = 3'd1;
    localparam logic [2:0] c_ACCESS = 3'd2;
    localparam logic [2:0] c_DONE   = 3'd3;
    localparam logic [2:0] c_CLEAR  = 3'd4;

    localparam logic [WORDS-1:0] c_ONE = {{(WORDS-1){1'b0}}, 1'b1};

    // State and latched transaction
    logic [2:0]       r_state;
    logic             r_id;       // granted requester
    logic             r_rw;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic             r_last;     // requester granted most recently

    // Next-state / next-latch values
    logic [2:0]       w_next;
    logic             w_id_n;
    logic             w_rw_n;
    logic [AW-1:0]    w_addr_n;
    logic [WIDTH-1:0] w_wdata_n;
    logic             w_gnt1;

    // Next output values (registered in the state process)
    logic             w_ack0_n;
    logic             w_ack1_n;
    logic             w_done_n;
    logic [WIDTH-1:0] w_rdata_n;
    logic             w_busy_n;
    logic [WORDS-1:0] w_add_n;
    logic             w_rw_out_n;
    logic [WIDTH-1:0] w_din_n;
    logic             w_clear_n;

    // ------------------------------------------------------------------
    // State register (also registers every output)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_id      <= 1'b0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_last    <= 1'b1;    // requester 0 wins the first tie
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            clr_done  <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_add   <= '0;
            mem_rw    <= 1'b0;
            mem_din   <= '0;
            mem_clear <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_id      <= w_id_n;
            r_rw      <= w_rw_n;
            r_addr    <= w_addr_n;
            r_wdata   <= w_wdata_n;
            if (r_state == c_ACCESS) begin
                r_last <= r_id;
            end
            ack0      <= w_ack0_n;
            ack1      <= w_ack1_n;
            clr_done  <= w_done_n;
            rdata     <= w_rdata_n;
            busy      <= w_busy_n;
            mem_add   <= w_add_n;
            mem_rw    <= w_rw_out_n;
            mem_din   <= w_din_n;
            mem_clear <= w_clear_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and arbitration
    // ------------------------------------------------------------------
    // On a tie, grant the requester that was not granted last.
    assign w_gnt1 = req1 & (~req0 | ~r_last);

    always_comb begin
        w_next    = c_IDLE;
        w_id_n    = r_id;
        w_rw_n    = r_rw;
        w_addr_n  = r_addr;
        w_wdata_n = r_wdata;
        case (r_state)
            c_IDLE: begin
                if (clr_req) begin
                    w_next = c_CLEAR;
                end else if (req0 | req1) begin
                    w_next    = c_SETUP;
                    w_id_n    = w_gnt1;
                    w_rw_n    = w_gnt1 ? rw1    : rw0;
                    w_addr_n  = w_gnt1 ? addr1  : addr0;
                    w_wdata_n = w_gnt1 ? wdata1 : wdata0;
                end else begin
                    w_next = c_IDLE;
                end
            end
            c_SETUP:  w_next = c_ACCESS;
            c_ACCESS: w_next = c_DONE;
            c_DONE:   w_next = c_IDLE;
            c_CLEAR:  w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: values the outputs take in the state being entered.
    // mem_din and rdata hold between transactions.
    // ------------------------------------------------------------------
    always_comb begin
        w_ack0_n   = 1'b0;
        w_ack1_n   = 1'b0;
        w_done_n   = 1'b0;
        w_rdata_n  = rdata;
        w_busy_n   = (w_next != c_IDLE);
        w_add_n    = '0;
        w_rw_out_n = 1'b0;
        w_din_n    = mem_din;
        w_clear_n  = 1'b0;
        case (w_next)
            c_SETUP: begin
                w_add_n = c_ONE << w_addr_n;
                w_din_n = w_wdata_n;
            end
            c_ACCESS: begin
                // Select and data already stable for a full cycle; strobe now.
                w_add_n    = c_ONE << w_addr_n;
                w_din_n    = w_wdata_n;
                w_rw_out_n = w_rw_n;
            end
            c_DONE: begin
                w_ack0_n  = ~w_id_n;
                w_ack1_n  = w_id_n;
                // Capture at the ACCESS exit edge; writes report zero.
                w_rdata_n = r_rw ? '0 : mem_dout;
            end
            c_CLEAR: begin
                w_clear_n = 1'b1;
                w_done_n  = 1'b1;
            end
            default: begin
                w_add_n = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_rr_ctrl
//  Purpose  : Self-checking bench for mem_rr_ctrl with a behavioural memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_rr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, rw0, rw1, clr_req;
    logic [1:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;
    logic       ack0, ack1, clr_done, busy, mem_rw, mem_clear;
    logic [3:0] rdata, mem_add, mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_rr_ctrl #(.WORDS(4), .WIDTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .clr_req(clr_req), .ack0(ack0), .ack1(ack1), .clr_done(clr_done),
        .rdata(rdata), .busy(busy), .mem_add(mem_add), .mem_rw(mem_rw),
        .mem_din(mem_din), .mem_clear(mem_clear), .mem_dout(mem_dout)
    );

    // Behavioural memory array seen by the controller
    logic [3:0] mem [4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_clear)                 mem[i] <= 4'd0;
            else if (mem_rw && mem_add[i]) mem[i] <= mem_din;
        end
    end
    always_comb begin
        mem_dout = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (mem_add[i]) mem_dout = mem_dout | mem[i];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs before an edge, outputs after it
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst, r0, w0;
        logic [1:0] a0;
        logic [3:0] d0;
        logic       r1, w1;
        logic [1:0] a1;
        logic [3:0] d1;
        logic       clr;
        logic       e_ack0, e_ack1, e_done, e_busy;
        logic [3:0] e_add;
        logic       e_rw, e_clr, c_rd;
        logic [3:0] e_rd;
        logic       c_din;
        logic [3:0] e_din;
    } vec_t;

    function automatic vec_t mk(input int rst, r0, w0, a0, d0, r1, w1, a1, d1, clr,
                                input int ea0, ea1, ed, eb, ead, erw, ec,
                                input int crd, erd, cdin, edin);
        vec_t v;
        v.rst = rst[0]; v.r0 = r0[0]; v.w0 = w0[0]; v.a0 = a0[1:0]; v.d0 = d0[3:0];
        v.r1 = r1[0]; v.w1 = w1[0]; v.a1 = a1[1:0]; v.d1 = d1[3:0]; v.clr = clr[0];
        v.e_ack0 = ea0[0]; v.e_ack1 = ea1[0]; v.e_done = ed[0]; v.e_busy = eb[0];
        v.e_add = ead[3:0]; v.e_rw = erw[0]; v.e_clr = ec[0];
        v.c_rd = crd[0]; v.e_rd = erd[3:0]; v.c_din = cdin[0]; v.e_din = edin[3:0];
        return v;
    endfunction

    vec_t tbl[22];

    // Reference-model state for the randomized phase
    logic [3:0] ref_mem [4];
    int  free_e, ack_e, acc_e, clr_e, busy_lo, busy_hi;
    bit  last_g, ack_id, exp_rw;
    logic [3:0] exp_rd, exp_add;

    initial begin
        //            rst r0 w0 a0 d0  r1 w1 a1 d1 clr | a0 a1 dn bsy add rw clr crd rd cdin din
        tbl[0]  = mk(1, 0,0,0,0,   0,0,0,0, 0,   0,0,0,0, 0,0,0, 1,0,  1,0);   // reset
        tbl[1]  = mk(0, 1,1,2,5,   0,0,0,0, 0,   0,0,0,1, 4,0,0, 0,0,  1,5);   // grant write -> SETUP
        tbl[2]  = mk(0, 1,0,0,15,  0,0,0,0, 0,   0,0,0,1, 4,1,0, 0,0,  1,5);   // ACCESS, inputs ignored
        tbl[3]  = mk(0, 1,0,0,15,  0,0,0,0, 0,   1,0,0,1, 0,0,0, 1,0,  0,0);   // DONE ack0, rdata 0
        tbl[4]  = mk(0, 1,0,0,15,  0,0,0,0, 0,   0,0,0,0, 0,0,0, 0,0,  0,0);   // IDLE
        tbl[5]  = mk(0, 1,0,2,0,   0,0,0,0, 0,   0,0,0,1, 4,0,0, 0,0,  0,0);   // grant read addr 2
        tbl[6]  = mk(0, 1,0,2,0,   0,0,0,0, 0,   0,0,0,1, 4,0,0, 0,0,  0,0);   // ACCESS, no strobe
        tbl[7]  = mk(0, 1,0,2,0,   0,0,0,0, 0,   1,0,0,1, 0,0,0, 1,5,  0,0);   // DONE rdata 0101
        tbl[8]  = mk(0, 1,0,2,0,   0,0,0,0, 0,   0,0,0,0, 0,0,0, 0,0,  0,0);   // IDLE
        tbl[9]  = mk(0, 1,0,2,0,   1,0,2,0, 1,   0,0,1,1, 0,0,1, 0,0,  0,0);   // clear wins
        tbl[10] = mk(0, 0,0,0,0,   1,0,3,0, 0,   0,0,0,0, 0,0,0, 0,0,  0,0);   // back to IDLE
        tbl[11] = mk(0, 0,0,0,0,   1,0,3,0, 0,   0,0,0,1, 8,0,0, 0,0,  0,0);   // read addr 3
        tbl[12] = mk(0, 0,0,0,0,   1,0,3,0, 0,   0,0,0,1, 8,0,0, 0,0,  0,0);
        tbl[13] = mk(0, 0,0,0,0,   1,0,3,0, 0,   0,1,0,1, 0,0,0, 1,0,  0,0);   // ack1, rdata 0
        tbl[14] = mk(0, 0,0,0,0,   1,0,3,0, 0,   0,0,0,0, 0,0,0, 0,0,  0,0);
        tbl[15] = mk(0, 1,1,1,14,  0,0,0,0, 0,   0,0,0,1, 2,0,0, 0,0,  1,14);  // write 1110 SETUP
        tbl[16] = mk(1, 1,1,1,14,  0,0,0,0, 0,   0,0,0,0, 0,0,0, 1,0,  1,0);   // reset mid-write
        tbl[17] = mk(0, 0,0,0,0,   0,0,0,0, 0,   0,0,0,0, 0,0,0, 0,0,  1,0);   // no ack
        tbl[18] = mk(0, 1,0,1,0,   0,0,0,0, 0,   0,0,0,1, 2,0,0, 0,0,  0,0);   // read addr 1
        tbl[19] = mk(0, 1,0,1,0,   0,0,0,0, 0,   0,0,0,1, 2,0,0, 0,0,  0,0);
        tbl[20] = mk(0, 1,0,1,0,   0,0,0,0, 0,   1,0,0,1, 0,0,0, 1,0,  0,0);   // aborted write absent
        tbl[21] = mk(0, 0,0,0,0,   0,0,0,0, 0,   0,0,0,0, 0,0,0, 0,0,  0,0);

        reset = 1'b1; req0 = 0; req1 = 0; rw0 = 0; rw1 = 0; clr_req = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            reset = tbl[i].rst; req0 = tbl[i].r0; rw0 = tbl[i].w0; addr0 = tbl[i].a0;
            wdata0 = tbl[i].d0; req1 = tbl[i].r1; rw1 = tbl[i].w1; addr1 = tbl[i].a1;
            wdata1 = tbl[i].d1; clr_req = tbl[i].clr;
            @(posedge clk); #1;
            check($sformatf("row%0d ack0", i), 32'(ack0), 32'(tbl[i].e_ack0));
            check($sformatf("row%0d ack1", i), 32'(ack1), 32'(tbl[i].e_ack1));
            check($sformatf("row%0d clr_done", i), 32'(clr_done), 32'(tbl[i].e_done));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("row%0d mem_add", i), 32'(mem_add), 32'(tbl[i].e_add));
            check($sformatf("row%0d mem_rw", i), 32'(mem_rw), 32'(tbl[i].e_rw));
            check($sformatf("row%0d mem_clear", i), 32'(mem_clear), 32'(tbl[i].e_clr));
            if (tbl[i].c_rd)  check($sformatf("row%0d rdata", i), 32'(rdata), 32'(tbl[i].e_rd));
            if (tbl[i].c_din) check($sformatf("row%0d mem_din", i), 32'(mem_din), 32'(tbl[i].e_din));
        end

        // ---- Tie after reset: grants alternate 0,1,0,1, one ack per 4 edges
        @(negedge clk); reset = 1'b1; req0 = 0; req1 = 0;
        @(posedge clk); #1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            reset = 1'b0; req0 = 1; req1 = 1; rw0 = 0; rw1 = 0;
            addr0 = 2'($urandom); addr1 = 2'($urandom);
            @(posedge clk); #1;
            check($sformatf("tie%0d ack0", j), 32'(ack0), 32'((j % 4 == 2) && ((j / 4) % 2 == 0)));
            check($sformatf("tie%0d ack1", j), 32'(ack1), 32'((j % 4 == 2) && ((j / 4) % 2 == 1)));
        end

        // ---- Back-to-back req1 with the address changing every cycle
        @(negedge clk); reset = 1'b1; req0 = 0; req1 = 0;
        @(posedge clk); #1;
        for (int j = 0; j < 12; j++) begin
            int g;
            logic [3:0] oh;
            logic [1:0] ga;
            @(negedge clk);
            reset = 1'b0; req1 = 1; rw1 = 1;
            addr1 = 2'((j + j / 4) % 4); wdata1 = 4'(j);
            @(posedge clk); #1;
            g  = j - (j % 4);
            ga = 2'((g + g / 4) % 4);
            oh = 4'b0001 << ga;
            check($sformatf("b2b%0d mem_add", j), 32'(mem_add), (j % 4 < 2) ? 32'(oh) : 32'd0);
            check($sformatf("b2b%0d ack1", j), 32'(ack1), 32'(j % 4 == 2));
        end

        // ---- Randomized traffic against a transaction-level model
        @(negedge clk); reset = 1'b1; req0 = 0; req1 = 0; clr_req = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) ref_mem[i] = 4'd0;
        free_e = 0; ack_e = -10; acc_e = -10; clr_e = -10; busy_lo = -10; busy_hi = -10;
        last_g = 1'b1; ack_id = 1'b0; exp_rw = 1'b0; exp_rd = 4'd0; exp_add = 4'd0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            reset = 1'b0;
            clr_req = (k == 0) ? 1'b1 : ($urandom_range(15) == 0);
            req0 = (k == 0) ? 1'b0 : ($urandom_range(2) != 0);
            req1 = (k == 0) ? 1'b0 : ($urandom_range(2) != 0);
            rw0 = 1'($urandom); rw1 = 1'($urandom);
            addr0 = 2'($urandom); addr1 = 2'($urandom);
            wdata0 = 4'($urandom); wdata1 = 4'($urandom);
            @(posedge clk);
            if (k >= free_e) begin
                if (clr_req) begin
                    for (int i = 0; i < 4; i++) ref_mem[i] = 4'd0;
                    clr_e = k; busy_lo = k; busy_hi = k; free_e = k + 2;
                end else if (req0 || req1) begin
                    bit id;
                    logic [1:0] a;
                    logic [3:0] d;
                    id = (req0 && req1) ? !last_g : req1;
                    exp_rw = id ? rw1 : rw0;
                    a = id ? addr1 : addr0;
                    d = id ? wdata1 : wdata0;
                    exp_rd = exp_rw ? 4'd0 : ref_mem[a];
                    if (exp_rw) ref_mem[a] = d;
                    exp_add = 4'b0001 << a;
                    last_g = id; ack_id = id;
                    acc_e = k + 1; ack_e = k + 2;
                    busy_lo = k; busy_hi = k + 2; free_e = k + 4;
                end
            end
            #1;
            check($sformatf("rnd%0d ack0", k), 32'(ack0), 32'(k == ack_e && !ack_id));
            check($sformatf("rnd%0d ack1", k), 32'(ack1), 32'(k == ack_e && ack_id));
            check($sformatf("rnd%0d clr_done", k), 32'(clr_done), 32'(k == clr_e));
            check($sformatf("rnd%0d mem_clear", k), 32'(mem_clear), 32'(k == clr_e));
            check($sformatf("rnd%0d busy", k), 32'(busy), 32'(k >= busy_lo && k <= busy_hi));
            check($sformatf("rnd%0d mem_rw", k), 32'(mem_rw), 32'(k == acc_e && exp_rw));
            check($sformatf("rnd%0d mem_add", k), 32'(mem_add),
                  (k == acc_e || k == acc_e - 1) ? 32'(exp_add) : 32'd0);
            if (k == ack_e) check($sformatf("rnd%0d rdata", k), 32'(rdata), 32'(exp_rd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
